// File: rtl/pu_pkg.sv
// Shared definitions for the PU residual-add control slice: controller
// state encoding and parameter defaults.
package pu_pkg;

  localparam int PU_PE_COL_NUM = 32;
  localparam int PU_RESI_WD    = 8;
  localparam int PU_ADDR_WD    = 12;
  localparam int PU_ROW_WD     = 8;
  localparam int PU_OCG_WD     = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pu_state_e;

endpackage

// File: rtl/pu_resi_fifo2.sv
// Two-entry residual row FIFO. Pointers and count are reset; the row
// storage is not, since it is only read while the count is non-zero.
module pu_resi_fifo2 #(
  parameter int WD = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [WD-1:0] push_data_i,
  input  logic          pop_i,
  output logic [WD-1:0] pop_data_o,
  output logic [1:0]    count_o,
  output logic          empty_o
);

  logic [WD-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clr_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // row storage
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = cnt_q;
  assign empty_o    = (cnt_q == 2'd0);

endmodule

// File: rtl/pu_resi_add_ctrl.sv
// Residual-add controller: fetches residual rows (oc-group outer, row inner)
// into a 2-entry FIFO and pairs each with an incoming PReLU row at the pipe.
module pu_resi_add_ctrl
  import pu_pkg::*;
#(
  parameter int PE_COL_NUM = PU_PE_COL_NUM,
  parameter int RESI_WD    = PU_RESI_WD,
  parameter int ADDR_WD    = PU_ADDR_WD,
  parameter int ROW_WD     = PU_ROW_WD,
  parameter int OCG_WD     = PU_OCG_WD
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cfg_start_i,
  input  logic                            cfg_bypass_i,
  input  logic [ROW_WD-1:0]               cfg_row_num_i,
  input  logic [OCG_WD-1:0]               cfg_ocg_num_i,
  input  logic [ADDR_WD-1:0]              cfg_base_addr_i,
  input  logic [ADDR_WD-1:0]              cfg_ocg_stride_i,
  output logic                            busy_o,
  output logic                            done_o,
  input  logic                            prelu_vld_i,
  output logic                            prelu_rdy_o,
  output logic                            resi_rd_en_o,
  output logic [ADDR_WD-1:0]              resi_rd_addr_o,
  input  logic [4*RESI_WD*PE_COL_NUM-1:0] resi_rd_data_i,
  output logic                            pipe_vld_o,
  input  logic                            pipe_rdy_i,
  output logic                            pipe_bypass_o,
  output logic [4*RESI_WD*PE_COL_NUM-1:0] pipe_resi_o,
  input  logic                            pipe_out_vld_i,
  input  logic                            pipe_out_rdy_i
);

  localparam int DW     = 4 * RESI_WD * PE_COL_NUM;
  localparam int CNT_WD = ROW_WD + OCG_WD;

  pu_state_e           state_q, state_d;
  logic                bypass_q;
  logic [ROW_WD-1:0]   row_num_q;
  logic [ADDR_WD-1:0]  stride_q;
  logic [CNT_WD-1:0]   total_q;
  logic [ROW_WD-1:0]   row_q;
  logic [ADDR_WD-1:0]  ocg_addr_q;
  logic [ADDR_WD-1:0]  addr_q;
  logic [CNT_WD-1:0]   rd_cnt_q;
  logic [CNT_WD-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_WD-1:0]   out_cnt_q, out_cnt_d;
  logic                ld_q;

  logic                start_acc;
  logic                is_run;
  logic                fifo_ok;
  logic                in_fire;
  logic                out_fire;
  logic                fifo_pop;
  logic                fifo_empty;
  logic [1:0]          fifo_cnt;
  logic [2:0]          occ;
  logic [DW-1:0]       fifo_data;

  assign start_acc = (state_q == ST_IDLE) & cfg_start_i;
  assign is_run    = (state_q == ST_RUN);
  assign fifo_ok   = bypass_q | ~fifo_empty;

  // Valid never looks at pipe_rdy_i; ready never looks at prelu_vld_i.
  assign pipe_vld_o  = is_run & prelu_vld_i & fifo_ok;
  assign prelu_rdy_o = is_run & pipe_rdy_i & fifo_ok;
  assign in_fire     = pipe_vld_o & pipe_rdy_i;
  assign fifo_pop    = in_fire & ~bypass_q;
  assign out_fire    = pipe_out_vld_i & pipe_out_rdy_i &
                       ((state_q == ST_RUN) | (state_q == ST_DRAIN));

  assign in_cnt_d  = in_cnt_q + CNT_WD'(in_fire);
  assign out_cnt_d = out_cnt_q + CNT_WD'(out_fire);

  // Occupancy credits this cycle's pop so a full-rate stream keeps one
  // entry resident plus one read in flight.
  assign occ = {1'b0, fifo_cnt} - {2'b00, fifo_pop} + {2'b00, ld_q};
  assign resi_rd_en_o = is_run & ~bypass_q & (rd_cnt_q != total_q) & (occ < 3'd2);
  assign resi_rd_addr_o = addr_q;

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign pipe_bypass_o = bypass_q & (state_q != ST_IDLE);
  assign pipe_resi_o   = fifo_data;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          if ((cfg_row_num_i == '0) || (cfg_ocg_num_i == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (in_cnt_d == total_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (out_cnt_d == total_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // layer shadows, beat counters and incremental address generation
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bypass_q   <= 1'b0;
      row_num_q  <= '0;
      stride_q   <= '0;
      total_q    <= '0;
      row_q      <= '0;
      ocg_addr_q <= '0;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      ld_q       <= 1'b0;
    end else begin
      ld_q <= resi_rd_en_o;
      if (start_acc) begin
        bypass_q   <= cfg_bypass_i;
        row_num_q  <= cfg_row_num_i;
        stride_q   <= cfg_ocg_stride_i;
        total_q    <= CNT_WD'(cfg_row_num_i) * CNT_WD'(cfg_ocg_num_i);
        row_q      <= '0;
        ocg_addr_q <= cfg_base_addr_i;
        addr_q     <= cfg_base_addr_i;
        rd_cnt_q   <= '0;
        in_cnt_q   <= '0;
        out_cnt_q  <= '0;
      end else begin
        in_cnt_q  <= in_cnt_d;
        out_cnt_q <= out_cnt_d;
        if (resi_rd_en_o) begin
          rd_cnt_q <= rd_cnt_q + CNT_WD'(1);
          if (row_q == row_num_q - ROW_WD'(1)) begin
            row_q      <= '0;
            ocg_addr_q <= ocg_addr_q + stride_q;
            addr_q     <= ocg_addr_q + stride_q;
          end else begin
            row_q  <= row_q + ROW_WD'(1);
            addr_q <= addr_q + ADDR_WD'(1);
          end
        end
      end
    end
  end

  pu_resi_fifo2 #(.WD(DW)) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .clr_i       (start_acc),
    .push_i      (ld_q),
    .push_data_i (resi_rd_data_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .count_o     (fifo_cnt),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_pu_resi_add_ctrl.sv
// Self-checking bench for pu_resi_add_ctrl: buffer and pipe models, a
// table of directed layers, randomized layers and reset/zero-size corners.
module tb_pu_resi_add_ctrl;

  localparam int DW = 4 * 8 * 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_start_i = 1'b0;
  logic          cfg_bypass_i = 1'b0;
  logic [7:0]    cfg_row_num_i = 8'd0;
  logic [5:0]    cfg_ocg_num_i = 6'd0;
  logic [11:0]   cfg_base_addr_i = 12'd0;
  logic [11:0]   cfg_ocg_stride_i = 12'd0;
  logic          busy_o, done_o;
  logic          prelu_vld_i = 1'b0;
  logic          prelu_rdy_o;
  logic          resi_rd_en_o;
  logic [11:0]   resi_rd_addr_o;
  logic [DW-1:0] resi_rd_data_i = '0;
  logic          pipe_vld_o;
  logic          pipe_rdy_i = 1'b0;
  logic          pipe_bypass_o;
  logic [DW-1:0] pipe_resi_o;
  logic          pipe_out_vld_i = 1'b0;
  logic          pipe_out_rdy_i = 1'b0;

  pu_resi_add_ctrl dut (
    .clk(clk), .rstn(rstn),
    .cfg_start_i(cfg_start_i), .cfg_bypass_i(cfg_bypass_i),
    .cfg_row_num_i(cfg_row_num_i), .cfg_ocg_num_i(cfg_ocg_num_i),
    .cfg_base_addr_i(cfg_base_addr_i), .cfg_ocg_stride_i(cfg_ocg_stride_i),
    .busy_o(busy_o), .done_o(done_o),
    .prelu_vld_i(prelu_vld_i), .prelu_rdy_o(prelu_rdy_o),
    .resi_rd_en_o(resi_rd_en_o), .resi_rd_addr_o(resi_rd_addr_o),
    .resi_rd_data_i(resi_rd_data_i),
    .pipe_vld_o(pipe_vld_o), .pipe_rdy_i(pipe_rdy_i),
    .pipe_bypass_o(pipe_bypass_o), .pipe_resi_o(pipe_resi_o),
    .pipe_out_vld_i(pipe_out_vld_i), .pipe_out_rdy_i(pipe_out_rdy_i)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          policy = 0;
  bit          tog = 1'b1;
  bit          rd_pend = 1'b0;
  logic [11:0] rd_pend_addr = 12'd0;
  int          pipe_cnt = 0;
  logic [31:0] salt = 32'd0;
  logic [11:0] exp_addr [$];
  bit          cur_bypass = 1'b0;
  int          rd_idx, in_beats, out_beats, done_cnt, done_cyc;
  int          first_in_cyc, last_in_cyc, last_out_cyc, occ, start_cyc;

  typedef struct {
    bit byp; int rows; int ocgs; int base; int stride; int pol;
    int exp_rd; int exp_beats; bit tp;
  } vec_t;
  vec_t vecs [5];

  function automatic logic [DW-1:0] mem_word(input logic [11:0] a);
    logic [31:0] w;
    w = {salt[19:0], a};
    return {32{w}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    logic [31:0] j;
    @(posedge clk);
    #1;
    cyc++;
    case (policy)
      0: begin prelu_vld_i = 1'b1; pipe_rdy_i = 1'b1; pipe_out_rdy_i = 1'b1; end
      1: begin prelu_vld_i = 1'b1; pipe_rdy_i = tog; tog = ~tog; pipe_out_rdy_i = 1'b1; end
      default: begin
        prelu_vld_i    = 1'($urandom_range(1));
        pipe_rdy_i     = 1'($urandom_range(1));
        pipe_out_rdy_i = 1'($urandom_range(1));
      end
    endcase
    pipe_out_vld_i = (pipe_cnt > 0);
    j = $urandom;
    resi_rd_data_i = rd_pend ? mem_word(rd_pend_addr) : {32{j}};
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (rd_pend) begin
        occ++;
        chk("fifo_occ_range", ((occ < 0) || (occ > 2)), 0);
      end
      if (pipe_vld_o && pipe_rdy_i) begin
        chk("prelu_rdy_at_beat", prelu_rdy_o, 1);
        chk("pipe_bypass", pipe_bypass_o, cur_bypass);
        if (!cur_bypass) begin
          checks++;
          if (in_beats >= exp_addr.size() || pipe_resi_o !== mem_word(exp_addr[in_beats])) begin
            failures++;
            $display("FAIL pipe_resi beat=%0d actual_lo=%0h", in_beats, pipe_resi_o[63:0]);
          end
          occ--;
          chk("fifo_occ_range", ((occ < 0) || (occ > 2)), 0);
        end
        if (first_in_cyc < 0) first_in_cyc = cyc;
        last_in_cyc = cyc;
        in_beats++;
        pipe_cnt++;
      end
      if (pipe_out_vld_i && pipe_out_rdy_i) begin
        out_beats++;
        pipe_cnt--;
        last_out_cyc = cyc;
      end
      if (resi_rd_en_o) begin
        if (rd_idx < exp_addr.size()) begin
          chk("rd_addr", resi_rd_addr_o, exp_addr[rd_idx]);
        end else begin
          checks++;
          failures++;
          $display("FAIL extra_read addr=%0h", resi_rd_addr_o);
        end
        rd_idx++;
      end
      rd_pend = resi_rd_en_o;
      rd_pend_addr = resi_rd_addr_o;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_model();
    rd_pend = 1'b0; pipe_cnt = 0; occ = 0;
    rd_idx = 0; in_beats = 0; out_beats = 0; done_cnt = 0; done_cyc = -1;
    first_in_cyc = -1; last_in_cyc = -1; last_out_cyc = -1;
  endtask

  task automatic start_layer(input bit byp, input int rows, input int ocgs,
                             input int base, input int stride, input int pol);
    salt = $urandom;
    policy = pol;
    tog = 1'b1;
    cur_bypass = byp;
    exp_addr.delete();
    if (!byp) begin
      for (int o = 0; o < ocgs; o++)
        for (int r = 0; r < rows; r++)
          exp_addr.push_back(12'(base + o * stride + r));
    end
    clear_model();
    cfg_bypass_i = byp;
    cfg_row_num_i = 8'(rows);
    cfg_ocg_num_i = 6'(ocgs);
    cfg_base_addr_i = 12'(base);
    cfg_ocg_stride_i = 12'(stride);
    cfg_start_i = 1'b1;
    start_cyc = cyc;
    cycle();
    cfg_start_i = 1'b0;
    cfg_bypass_i = 1'($urandom_range(1));
    cfg_row_num_i = 8'($urandom);
    cfg_ocg_num_i = 6'($urandom);
    cfg_base_addr_i = 12'($urandom);
    cfg_ocg_stride_i = 12'($urandom);
  endtask

  task automatic finish_layer(input int exp_rd, input int exp_beats, input bit tp);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      if (i == 1 && busy_o) cfg_start_i = 1'b1;
      cycle();
      cfg_start_i = 1'b0;
    end
    if (done_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL layer_timeout in_beats=%0d out_beats=%0d", in_beats, out_beats);
    end
    cycle();
    cycle();
    chk("rd_count", rd_idx, exp_rd);
    chk("in_beats", in_beats, exp_beats);
    chk("out_beats", out_beats, exp_beats);
    chk("done_pulses", done_cnt, 1);
    chk("done_after_last_out", done_cyc, last_out_cyc + 1);
    chk("busy_idle", busy_o, 0);
    if (tp) chk("back_to_back", last_in_cyc - first_in_cyc, exp_beats - 1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pipe_vld", pipe_vld_o, 0);
    chk("rst_prelu_rdy", prelu_rdy_o, 0);
    chk("rst_rd_en", resi_rd_en_o, 0);
    chk("rst_rd_addr", resi_rd_addr_o, 0);
    chk("rst_bypass", pipe_bypass_o, 0);
  endtask

  initial begin
    bit rb;
    int rr, ro, lat;

    vecs[0] = '{1'b0, 4, 2, 'h100, 'h20, 0, 8, 8, 1'b1};
    vecs[1] = '{1'b1, 3, 1, 'h040, 'h10, 0, 0, 3, 1'b1};
    vecs[2] = '{1'b0, 8, 1, 'h200, 'h00, 1, 8, 8, 1'b0};
    vecs[3] = '{1'b0, 4, 1, 'hFFE, 'h00, 0, 4, 4, 1'b1};
    vecs[4] = '{1'b0, 3, 3, 'hFF0, 'h7F8, 2, 9, 9, 1'b0};

    clear_model();
    cycle();
    cycle();
    chk_reset_outs();
    rstn = 1'b1;
    cycle();

    for (int v = 0; v < 5; v++) begin
      start_layer(vecs[v].byp, vecs[v].rows, vecs[v].ocgs, vecs[v].base, vecs[v].stride, vecs[v].pol);
      finish_layer(vecs[v].exp_rd, vecs[v].exp_beats, vecs[v].tp);
    end

    // zero-sized layers: rows = 0, then oc groups = 0
    for (int z = 0; z < 2; z++) begin
      start_layer(1'b0, (z == 0) ? 0 : 5, (z == 0) ? 3 : 0, 'h123, 'h10, 0);
      for (int i = 0; i < 4; i++) cycle();
      lat = done_cyc - start_cyc;
      chk("zero_done_pulses", done_cnt, 1);
      chk("zero_done_latency_ok", ((lat >= 1) && (lat <= 2)), 1);
      chk("zero_reads", rd_idx, 0);
      chk("zero_beats", in_beats, 0);
      chk("zero_busy_idle", busy_o, 0);
    end

    for (int k = 0; k < 6; k++) begin
      rb = ($urandom_range(3) == 0);
      rr = $urandom_range(6, 1);
      ro = $urandom_range(3, 1);
      start_layer(rb, rr, ro, $urandom_range(4095), $urandom_range(4095), 2);
      finish_layer(rb ? 0 : rr * ro, rr * ro, 1'b0);
    end

    // reset in the middle of a layer, then a fresh layer
    start_layer(1'b0, 8, 1, 'h300, 'h00, 0);
    for (int i = 0; i < 200 && in_beats < 3; i++) cycle();
    chk("mid_reset_beats_before", in_beats, 3);
    rstn = 1'b0;
    #1;
    chk_reset_outs();
    clear_model();
    cycle();
    cycle();
    chk_reset_outs();
    rstn = 1'b1;
    start_layer(1'b0, 8, 1, 'h0A0, 'h00, 0);
    finish_layer(8, 8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pu_resi_add_ctrl.md
PU_RESI_ADD_CTRL -- requirements
Module: pu_resi_add_ctrl

Interface
REQ-001 SHALL have parameters: PE_COL_NUM, default 32, output columns per row; RESI_WD, default 8, residual element width; ADDR_WD, default 12, residual buffer address width; ROW_WD, default 8, row counter width; OCG_WD, default 6, oc-group (4 oc) counter width.
REQ-002 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cfg_start_i  in  1  layer start pulse; cfg_bypass_i  in  1  skip residual add; cfg_row_num_i  in  ROW_WD  rows per oc group; cfg_ocg_num_i  in  OCG_WD  oc groups; cfg_base_addr_i  in  ADDR_WD  residual base; cfg_ocg_stride_i  in  ADDR_WD  address step per oc group.
REQ-005 SHALL have ports busy_o  out  1  layer active; done_o  out  1  one-cycle completion pulse.
REQ-006 SHALL have ports prelu_vld_i  in  1  prelu row valid; prelu_rdy_o  out  1  prelu row accepted.
REQ-007 SHALL have ports resi_rd_en_o  out  1  buffer read strobe; resi_rd_addr_o  out  ADDR_WD  read address; resi_rd_data_i  in  4*RESI_WD*PE_COL_NUM  read data {oc0,oc1,oc2,oc3}, valid exactly 1 cycle after resi_rd_en_o.
REQ-008 SHALL have ports pipe_vld_o  out  1  to resi-add pipe input valid; pipe_rdy_i  in  1  pipe input ready; pipe_bypass_o  out  1  bypass to pipe; pipe_resi_o  out  4*RESI_WD*PE_COL_NUM  residual row to pipe; pipe_out_vld_i  in  1  pipe output valid; pipe_out_rdy_i  in  1  downstream ready at pipe output.

Function
REQ-009 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-010 IDLE: cfg_start_i latches all cfg_* into shadow registers, clears counters, goes to RUN; if row_num==0 or ocg_num==0, goes to DONE instead (no reads, no beats).
REQ-011 cfg_start_i outside IDLE SHALL be ignored; shadow registers stay constant until the next IDLE.
REQ-012 Issue order SHALL be ocg outer, row inner; address = base + ocg*ocg_stride + row, computed incrementally (no multiplier), ADDR_WD wrap-around modulo 2^ADDR_WD.
REQ-013 Residual data SHALL land in a 2-entry FIFO; a read issues in RUN when (fifo_count + inflight) < 2 and issued reads < total = row_num*ocg_num; at most 1 read per cycle.
REQ-014 In bypass mode no reads SHALL issue; pipe_resi_o is don't-care.
REQ-015 pipe_vld_o = RUN & prelu_vld_i & (bypass | fifo non-empty); prelu_rdy_o = RUN & pipe_rdy_i & (bypass | fifo non-empty); no combinational path from pipe_rdy_i to pipe_vld_o.
REQ-016 Input beat fires on pipe_vld_o & pipe_rdy_i: FIFO pops (non-bypass), input beat counter increments; FIFO push and pop in the same cycle SHALL keep the count unchanged.
REQ-017 pipe_bypass_o SHALL equal the shadowed bypass flag from RUN until IDLE.
REQ-018 After the input beat counter reaches total, FSM SHALL go to DRAIN; output beat counter counts pipe_out_vld_i & pipe_out_rdy_i in RUN and DRAIN.
REQ-019 DRAIN -> DONE when output count == total (including the same cycle the last output beat fires); DONE lasts exactly 1 cycle with done_o=1, then IDLE.
REQ-020 busy_o = 1 in RUN, DRAIN, DONE; 0 in IDLE.
REQ-021 Read-to-data latency SHALL be tolerated with any pipe_rdy_i stall pattern; FIFO SHALL never overflow or be read empty.
REQ-022 Total throughput SHALL be 1 beat/cycle when prelu_vld_i and pipe_rdy_i are held high.

Reset
REQ-023 On rstn low: FSM=IDLE, counters=0, FIFO empty, inflight=0, busy_o=0, done_o=0, pipe_vld_o=0, prelu_rdy_o=0, resi_rd_en_o=0, resi_rd_addr_o=0, pipe_bypass_o=0; FIFO data storage needs no reset.
REQ-024 Reset asserted mid-layer SHALL abort immediately; read data returning after reset release SHALL be discarded.

Structure
REQ-025 FSM state encoding and parameter defaults SHALL live in shared package pu_pkg.
REQ-026 The 2-entry residual FIFO SHALL be sub-module pu_resi_fifo2; the controller owns counters, address generation and FSM.

Verification
REQ-027 row_num=4, ocg_num=2, base=0x100, stride=0x20, all ready high -> reads 0x100..0x103,0x120..0x123; 8 pipe beats back-to-back; done_o 1 cycle after 8th output beat.
REQ-028 bypass=1, row_num=3, ocg_num=1 -> zero resi_rd_en_o pulses; 3 beats with pipe_bypass_o=1; done_o after 3 outputs.
REQ-029 pipe_rdy_i toggling 1-0 every cycle, row_num=8, ocg_num=1 -> 8 beats, data in address order, FIFO count never >2.
REQ-030 row_num=0 start -> done_o pulses 2 cycles after cfg_start_i, no reads, no beats.
REQ-031 base=0xFFE, row_num=4 -> addresses 0xFFE,0xFFF,0x000,0x001.
REQ-032 rstn asserted after 3 of 8 beats -> all outputs at reset values; new cfg_start_i completes fresh layer of 8 beats.
